uvma_clk_div_gen: RTL and testbench

- Programmable, glitch-free clock divider that generates the divided clock driven onto uvma_clk_if.
- Sits directly upstream of the clock interface and its checker.
- Derives clk_out from the single reference clock and accepts ratio changes over a valid/ready handshake; changes take effect only on period boundaries.
- Provides start/stop control and edge-strobe outputs for the monitor and checker.

---
 rtl/uvma_clk_div_gen.sv | 175 +++++++++++++++++
 tb/tb_uvma_clk_div_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvma_clk_div_gen.sv
// Programmable glitch-free clock divider: clk_out period = N clk cycles, ratio
// changes over valid/ready land on period boundaries. Optional macro: UVMA_CLK_DIV_GEN_CYCLE_CNT_EN.
module uvma_clk_div_gen #(
  parameter int DIV_W       = 8,
  parameter int RESET_RATIO = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] ratio,
  input  logic             ratio_valid,
  output logic             ratio_ready,
  output logic             ratio_err,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic [31:0]      cycle_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a ratio transfers on any rising clk edge where ratio_valid && ratio_ready;
  // ratio_valid may be held or dropped freely, ratio_ready depends only on internal state.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] RESET_R = DIV_W'(RESET_RATIO);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);

  function automatic logic [DIV_W-1:0] high_len_m1(input logic [DIV_W-1:0] n);
    return n - (n >> 1) - ONE;
  endfunction

  function automatic logic [DIV_W-1:0] low_len_m1(input logic [DIV_W-1:0] n);
    return (n >> 1) - ONE;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] active_q, active_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] eff_ratio;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    err_d      = 1'b0;
    eff_ratio  = pend_vld_q ? pend_q : active_q;
    accept     = ratio_valid && !pend_vld_q;

    case (state_q)
      ST_IDLE: begin
        clk_out_d  = 1'b0;
        active_d   = eff_ratio;
        pend_vld_d = 1'b0;
        if (en) begin
          state_d   = ST_HIGH;
          cnt_d     = high_len_m1(eff_ratio);
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d   = ST_LOW;
          cnt_d     = low_len_m1(active_q);
          clk_out_d = 1'b0;
          fall_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          // Period boundary: the only place a pending ratio may take effect while running.
          active_d   = eff_ratio;
          pend_vld_d = 1'b0;
          if (en) begin
            state_d   = ST_HIGH;
            cnt_d     = high_len_m1(eff_ratio);
            clk_out_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            clk_out_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clk_out_d = 1'b0;
      end
    endcase

    // accept implies the slot was empty, so this never overrides a consumption.
    if (accept) begin
      if (ratio < TWO) begin
        err_d = 1'b1;
      end else begin
        pend_d     = ratio;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      active_q   <= RESET_R;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_q      <= err_d;
    end
  end

`ifdef UVMA_CLK_DIV_GEN_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (rise_d) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

  assign ratio_ready = !pend_vld_q;
  assign ratio_err   = err_q;
  assign clk_out     = clk_out_q;
  assign rise_stb    = rise_q;
  assign fall_stb    = fall_q;
  assign running     = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uvma_clk_div_gen.sv
// Directed bench for uvma_clk_div_gen: inputs driven and outputs sampled on the falling
// clk edge; expected waveforms are hand-derived per scenario.
module tb_uvma_clk_div_gen;

  logic        clk;
  logic        reset;
  logic        en;
  logic [7:0]  ratio;
  logic        ratio_valid;
  logic        ratio_ready;
  logic        ratio_err;
  logic        clk_out;
  logic        rise_stb;
  logic        fall_stb;
  logic        running;
  logic [31:0] cycle_cnt;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        cap_clk [64];
  logic        cap_rise[64];
  logic        cap_fall[64];
  logic        cap_run [64];
  logic        cap_rdy [64];
  logic        cap_err [64];
  logic [31:0] cap_cyc [64];

  uvma_clk_div_gen #(.DIV_W(8), .RESET_RATIO(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .ratio_ready (ratio_ready),
    .ratio_err   (ratio_err),
    .clk_out     (clk_out),
    .rise_stb    (rise_stb),
    .fall_stb    (fall_stb),
    .running     (running),
    .cycle_cnt   (cycle_cnt),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record outputs after each of the next n rising edges; valid is one-shot.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_clk[i]  = clk_out;
      cap_rise[i] = rise_stb;
      cap_fall[i] = fall_stb;
      cap_run[i]  = running;
      cap_rdy[i]  = ratio_ready;
      cap_err[i]  = ratio_err;
      cap_cyc[i]  = cycle_cnt;
      ratio_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!running) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_ratio_idle(input logic [7:0] r);
    ratio       = r;
    ratio_valid = 1'b1;
    @(negedge clk);
    ratio_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; ratio = 8'd0; ratio_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({clk_out, rise_stb, fall_stb, running, ratio_err, ratio_ready} !== 6'b000001) begin
      tests_failed++;
      $display("FAIL reset_outputs: got clk/rise/fall/run/err/rdy=%b expected 000001",
               {clk_out, rise_stb, fall_stb, running, ratio_err, ratio_ready});
    end
    tests_run++;
    if (cycle_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_cycle_cnt: got %0d expected 0", cycle_cnt);
    end
  endtask

  task automatic test_default_ratio;
    bit ok;
    en = 1'b1;
    capture(8);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({cap_clk[i], cap_rise[i], cap_fall[i], cap_run[i]} !==
          {(i % 2 == 0), (i % 2 == 0), (i % 2 == 1), 1'b1}) begin
        tests_failed++;
        $display("FAIL default_n2[%0d]: got clk/rise/fall/run=%b%b%b%b expected %b%b%b1", i,
                 cap_clk[i], cap_rise[i], cap_fall[i], cap_run[i],
                 (i % 2 == 0), (i % 2 == 0), (i % 2 == 1));
      end
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL default_stop: got idle_reached=%0d clk_out=%b expected 1/0", ok, clk_out);
    end
  endtask

  task automatic test_ratio_idle5;
    int rises;
    ratio = 8'd5; ratio_valid = 1'b1;
    @(negedge clk);
    ratio_valid = 1'b0;
    tests_run++;
    if (ratio_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle5_ready_drop: got %b expected 0", ratio_ready);
    end
    @(negedge clk);
    tests_run++;
    if (ratio_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle5_ready_back: got %b expected 1", ratio_ready);
    end
    en = 1'b1;
    capture(20);
    en = 1'b0;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      rises += int'(cap_rise[i]);
      tests_run++;
      if ({cap_clk[i], cap_rise[i], cap_fall[i]} !==
          {((i % 5) < 3), ((i % 5) == 0), ((i % 5) == 3)}) begin
        tests_failed++;
        $display("FAIL idle5_pattern[%0d]: got clk/rise/fall=%b%b%b expected %b%b%b", i,
                 cap_clk[i], cap_rise[i], cap_fall[i],
                 ((i % 5) < 3), ((i % 5) == 0), ((i % 5) == 3));
      end
    end
    capture(2);
    rises += int'(cap_rise[0]) + int'(cap_rise[1]);
    tests_run++;
    if (rises != 4 || cap_run[0] !== 1'b0 || cap_clk[1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle5_four_periods: got rises=%0d run=%b clk=%b expected 4/0/0",
               rises, cap_run[0], cap_clk[1]);
    end
  endtask

  task automatic test_ratio_change;
    bit ok;
    logic exp_clk [10] = '{1, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    logic exp_rdy [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    set_ratio_idle(8'd4);
    en = 1'b1;
    @(negedge clk);
    ratio = 8'd6; ratio_valid = 1'b1;
    capture(10);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (cap_clk[i] !== exp_clk[i] || cap_rdy[i] !== exp_rdy[i]) begin
        tests_failed++;
        $display("FAIL change_4to6[%0d]: got clk=%b rdy=%b expected clk=%b rdy=%b", i,
                 cap_clk[i], cap_rdy[i], exp_clk[i], exp_rdy[i]);
      end
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL change_stop: got idle_reached=0 expected 1");
    end
  endtask

  task automatic test_illegal_ratio;
    bit ok;
    logic [7:0] bad [2] = '{8'd1, 8'd0};
    for (int k = 0; k < 2; k++) begin
      ratio = bad[k]; ratio_valid = 1'b1;
      @(negedge clk);
      ratio_valid = 1'b0;
      tests_run++;
      if (ratio_err !== 1'b1 || ratio_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL illegal_%0d_pulse: got err=%b rdy=%b expected 1/1", bad[k],
                 ratio_err, ratio_ready);
      end
      @(negedge clk);
      tests_run++;
      if (ratio_err !== 1'b0 || ratio_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL illegal_%0d_clear: got err=%b rdy=%b expected 0/1", bad[k],
                 ratio_err, ratio_ready);
      end
    end
    en = 1'b1;
    capture(12);
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (cap_clk[i] !== ((i % 6) < 3) || cap_err[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL illegal_keep_n6[%0d]: got clk=%b err=%b expected %b/0", i,
                 cap_clk[i], cap_err[i], ((i % 6) < 3));
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_en_stop;
    bit ok;
    logic exp_clk [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    logic exp_run [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    logic exp_fall[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    set_ratio_idle(8'd8);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    capture(8);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({cap_clk[i], cap_run[i], cap_fall[i], cap_rise[i]} !==
          {exp_clk[i], exp_run[i], exp_fall[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL en_stop_n8[%0d]: got clk/run/fall/rise=%b%b%b%b expected %b%b%b0", i,
                 cap_clk[i], cap_run[i], cap_fall[i], cap_rise[i],
                 exp_clk[i], exp_run[i], exp_fall[i]);
      end
    end
    en = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({clk_out, rise_stb, running} !== 3'b111) begin
      tests_failed++;
      $display("FAIL en_restart: got clk/rise/run=%b expected 111", {clk_out, rise_stb, running});
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid;
    set_ratio_idle(8'd6);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({clk_out, running, ratio_ready} !== 3'b001 || cycle_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: got clk/run/rdy=%b cnt=%0d expected 001/0",
               {clk_out, running, ratio_ready}, cycle_cnt);
    end
    capture(6);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (cap_clk[i] !== (i % 2 == 0)) begin
        tests_failed++;
        $display("FAIL reset_mid_n2[%0d]: got clk=%b expected %b", i, cap_clk[i], (i % 2 == 0));
      end
    end
    tests_run++;
`ifdef UVMA_CLK_DIV_GEN_CYCLE_CNT_EN
    if (cap_cyc[5] !== 32'd3) begin
      tests_failed++;
      $display("FAIL reset_mid_cycle_cnt: got %0d expected 3", cap_cyc[5]);
    end
`else
    if (cap_cyc[5] !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_cycle_cnt: got %0d expected 0", cap_cyc[5]);
    end
`endif
    en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ratio = 8'd0; ratio_valid = 1'b0;
    test_reset;
    test_default_ratio;
    test_ratio_idle5;
    test_ratio_change;
    test_illegal_ratio;
    test_en_stop;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
